// File: rtl/pipelined_float_to_int_pkg.sv
// Shared float constants and stage payload types for the float-to-int pipeline.
// Used by pipelined_float_to_int and float_to_int_round_stage.
package pipelined_float_to_int_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 1;
    localparam int INT_W    = 32;
    localparam int EXP_BIAS = 127;

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_DOWN    = 2'b01;
    localparam logic [1:0] RM_UP      = 2'b10;
    localparam logic [1:0] RM_ZERO    = 2'b11;

    localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    // Biased exponents bounding the shift window: E=-1 and E=31.
    localparam logic [EXP_W-1:0] EXP_HALF = 8'(EXP_BIAS - 1);
    localparam logic [EXP_W-1:0] EXP_OVF  = 8'(EXP_BIAS + 31);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              is_nan;
        logic              is_inf;
        logic [1:0]        rm;
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic [INT_W-1:0]  int_mag;
        logic              guard;
        logic              rnd;
        logic              sticky;
        logic              pre_ovf;
        logic              is_nan;
        logic              is_inf;
        logic [1:0]        rm;
    } s2_t;

endpackage

// File: rtl/pipelined_float_to_int_round_stage.sv
// Round, negate and saturate logic for the last pipeline stage (purely combinational).
// Flag outputs exist only when F2I_FLAGS_EN is defined.
module float_to_int_round_stage
    import pipelined_float_to_int_pkg::*;
(
    input  s2_t              stg,
`ifdef F2I_FLAGS_EN
    output logic             invalid,
    output logic             inexact,
`endif
    output logic [INT_W-1:0] d
);

    logic             inc;
    logic             grs;
    logic             sat_pos;
    logic             sat_neg;
    logic [INT_W:0]   mag;

    always_comb begin
        grs = stg.guard | stg.rnd | stg.sticky;
        case (stg.rm)
            RM_NEAREST: inc = stg.guard & (stg.rnd | stg.sticky | stg.int_mag[0]);
            RM_DOWN:    inc = stg.sign & grs;
            RM_UP:      inc = ~stg.sign & grs;
            default:    inc = 1'b0;
        endcase

        // 33-bit magnitude so a carry out of 2^31-1 is visible to the range check.
        mag = {1'b0, stg.int_mag} + {{INT_W{1'b0}}, inc};

        sat_pos = stg.is_nan |
                  (~stg.sign & (stg.is_inf | stg.pre_ovf | (mag > {1'b0, INT_MAX})));
        sat_neg = ~stg.is_nan & stg.sign &
                  (stg.is_inf | stg.pre_ovf | (mag > {1'b0, INT_MIN}));

        if (sat_pos) begin
            d = INT_MAX;
        end else if (sat_neg) begin
            d = INT_MIN;
        end else if (stg.sign) begin
            d = ~mag[INT_W-1:0] + 32'd1;
        end else begin
            d = mag[INT_W-1:0];
        end
    end

`ifdef F2I_FLAGS_EN
    assign invalid = sat_pos | sat_neg;
    assign inexact = grs & ~(sat_pos | sat_neg);
`endif

endmodule

// File: rtl/pipelined_float_to_int.sv
// Three-stage IEEE-754 single to signed 32-bit integer converter with rounding modes.
// Define F2I_FLAGS_EN to add the invalid/inexact flag outputs.
module pipelined_float_to_int
    import pipelined_float_to_int_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic             e,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [1:0]       rm,
`ifdef F2I_FLAGS_EN
    output logic             invalid,
    output logic             inexact,
`endif
    output logic             out_valid,
    output logic [INT_W-1:0] d
);

    s1_t               s1_next;
    s1_t               s1_reg;
    logic              s1_valid_reg;
    s2_t               s2_next;
    s2_t               s2_reg;
    logic              s2_valid_reg;
    logic [INT_W-1:0]  d_next;
    logic [55:0]       fixed_val;
    logic [5:0]        sh;
    logic              min_exact;

    // S1: unpack and classify.
    always_comb begin
        s1_next.sign   = a[31];
        s1_next.exp    = a[30:23];
        s1_next.mant   = {|a[30:23], a[22:0]};
        s1_next.is_nan = (&a[30:23]) & (|a[22:0]);
        s1_next.is_inf = (&a[30:23]) & ~(|a[22:0]);
        s1_next.rm     = rm;
    end

    // S2: place the mantissa so bit 25 is the integer LSB, bits 24/23 are guard/round.
    always_comb begin
        s2_next         = '0;
        s2_next.sign    = s1_reg.sign;
        s2_next.is_nan  = s1_reg.is_nan;
        s2_next.is_inf  = s1_reg.is_inf;
        s2_next.rm      = s1_reg.rm;
        fixed_val       = '0;
        sh              = '0;
        // -2^31 is the only representable value with E=31.
        min_exact       = (s1_reg.exp == EXP_OVF) && s1_reg.sign &&
                          (s1_reg.mant[FRAC_W-1:0] == '0);

        if (s1_reg.exp >= EXP_OVF) begin
            if (min_exact) begin
                s2_next.int_mag = INT_MIN;
            end else begin
                s2_next.pre_ovf = 1'b1;
            end
        end else if (s1_reg.exp < EXP_HALF) begin
            s2_next.sticky = |s1_reg.mant;
        end else begin
            sh              = 6'(s1_reg.exp - (EXP_HALF - 8'd1));
            fixed_val       = 56'(s1_reg.mant) << sh;
            s2_next.int_mag = {1'b0, fixed_val[55:25]};
            s2_next.guard   = fixed_val[24];
            s2_next.rnd     = fixed_val[23];
            s2_next.sticky  = |fixed_val[22:0];
        end
    end

`ifdef F2I_FLAGS_EN
    logic invalid_next;
    logic inexact_next;
`endif

    // S3 combinational stage.
    float_to_int_round_stage u_round (
        .stg     (s2_reg),
`ifdef F2I_FLAGS_EN
        .invalid (invalid_next),
        .inexact (inexact_next),
`endif
        .d       (d_next)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_reg       <= '0;
            s1_valid_reg <= 1'b0;
            s2_reg       <= '0;
            s2_valid_reg <= 1'b0;
            out_valid    <= 1'b0;
            d            <= '0;
        end else if (e) begin
            s1_reg       <= s1_next;
            s1_valid_reg <= in_valid;
            s2_reg       <= s2_next;
            s2_valid_reg <= s1_valid_reg;
            out_valid    <= s2_valid_reg;
            d            <= d_next;
        end
    end

`ifdef F2I_FLAGS_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else if (e) begin
            invalid <= invalid_next;
            inexact <= inexact_next;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_float_to_int.sv
// Table-driven scoreboard bench for pipelined_float_to_int (flag checks when F2I_FLAGS_EN is defined).
module tb_pipelined_float_to_int;

    logic        clk;
    logic        clrn;
    logic        e;
    logic        in_valid;
    logic [31:0] a;
    logic [1:0]  rm;
    logic        out_valid;
    logic [31:0] d;
`ifdef F2I_FLAGS_EN
    logic        invalid;
    logic        inexact;
`endif

    pipelined_float_to_int dut (
        .clk       (clk),
        .clrn      (clrn),
        .e         (e),
        .in_valid  (in_valid),
        .a         (a),
        .rm        (rm),
`ifdef F2I_FLAGS_EN
        .invalid   (invalid),
        .inexact   (inexact),
`endif
        .out_valid (out_valid),
        .d         (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  rm;
        logic [31:0] d;
        logic        inv;
        logic        inx;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        inv;
        logic        inx;
        int          tag;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  held;
    logic held_valid = 1'b0;
    int   adv_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic add(input logic [31:0] av, input logic [1:0] rmv, input logic [31:0] dv,
                       input logic inv, input logic inx);
        vec_t v;
        v.a = av; v.rm = rmv; v.d = dv; v.inv = inv; v.inx = inx;
        vecs.push_back(v);
    endtask

    task automatic check_result(input sb_t got);
        chk("latency", 32'(adv_cnt), 32'(got.tag + 2));
        chk("d", d, got.d);
`ifdef F2I_FLAGS_EN
        chk("invalid", {31'b0, invalid}, {31'b0, got.inv});
        chk("inexact", {31'b0, inexact}, {31'b0, got.inx});
`endif
        $display("result a=%h d=%h expected=%h", got.a, d, got.d);
    endtask

    // One clock: drive, let the edge happen, then compare 1 time unit later.
    task automatic tick(input logic e_v, input logic iv, input vec_t v);
        sb_t ent;
        sb_t got;
        e = e_v; in_valid = iv; a = v.a; rm = v.rm;
        @(posedge clk);
        if (clrn && e_v) begin
            adv_cnt++;
            if (iv) begin
                ent.a = v.a; ent.d = v.d; ent.inv = v.inv; ent.inx = v.inx; ent.tag = adv_cnt;
                sb.push_back(ent);
            end
        end
        #1;
        if (clrn && e_v) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                    held_valid = 1'b0;
                end else begin
                    got = sb.pop_front();
                    check_result(got);
                    held = got;
                    held_valid = 1'b1;
                end
            end else begin
                if (sb.size() != 0 && sb[0].tag + 2 <= adv_cnt) begin
                    chk("missing_out_valid", {31'b0, out_valid}, 32'd1);
                    void'(sb.pop_front());
                end
                held_valid = 1'b0;
            end
        end else begin
            chk("hold_valid", {31'b0, out_valid}, {31'b0, held_valid});
            if (held_valid) begin
                chk("hold_d", d, held.d);
`ifdef F2I_FLAGS_EN
                chk("hold_invalid", {31'b0, invalid}, {31'b0, held.inv});
                chk("hold_inexact", {31'b0, inexact}, {31'b0, held.inx});
`endif
            end
        end
    endtask

    task automatic idle(input int n);
        vec_t z;
        z.a = '0; z.rm = '0; z.d = '0; z.inv = 1'b0; z.inx = 1'b0;
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, z);
    endtask

    function automatic vec_t mk(input logic [31:0] av, input logic [31:0] dv);
        vec_t v;
        v.a = av; v.rm = 2'b00; v.d = dv; v.inv = 1'b0; v.inx = 1'b0;
        return v;
    endfunction

    initial begin
        vec_t junk;
        clrn = 1'b0; e = 1'b0; in_valid = 1'b0; a = '0; rm = '0;

        // a, rm, d, invalid, inexact
        add(32'h3FC00000, 2'b00, 32'h00000002, 1'b0, 1'b1);
        add(32'h40200000, 2'b00, 32'h00000002, 1'b0, 1'b1);
        add(32'h40200000, 2'b10, 32'h00000003, 1'b0, 1'b1);
        add(32'h40200000, 2'b11, 32'h00000002, 1'b0, 1'b1);
        add(32'h40200000, 2'b01, 32'h00000002, 1'b0, 1'b1);
        add(32'hBF800000, 2'b00, 32'hFFFFFFFF, 1'b0, 1'b0);
        add(32'hBF800000, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0);
        add(32'hBF800000, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b0);
        add(32'hBF800000, 2'b11, 32'hFFFFFFFF, 1'b0, 1'b0);
        add(32'h80000001, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b1);
        add(32'h80000001, 2'b00, 32'h00000000, 1'b0, 1'b1);
        add(32'h80000001, 2'b10, 32'h00000000, 1'b0, 1'b1);
        add(32'h00000001, 2'b10, 32'h00000001, 1'b0, 1'b1);
        add(32'h80400000, 2'b11, 32'h00000000, 1'b0, 1'b1);
        add(32'hCF000000, 2'b00, 32'h80000000, 1'b0, 1'b0);
        add(32'h4F000000, 2'b00, 32'h7FFFFFFF, 1'b1, 1'b0);
        add(32'h7FC00000, 2'b00, 32'h7FFFFFFF, 1'b1, 1'b0);
        add(32'hFFC00000, 2'b01, 32'h7FFFFFFF, 1'b1, 1'b0);
        add(32'hFF800000, 2'b00, 32'h80000000, 1'b1, 1'b0);
        add(32'h7F800000, 2'b11, 32'h7FFFFFFF, 1'b1, 1'b0);
        add(32'hCF000001, 2'b00, 32'h80000000, 1'b1, 1'b0);
        add(32'h5F000000, 2'b10, 32'h7FFFFFFF, 1'b1, 1'b0);
        add(32'hDF000000, 2'b01, 32'h80000000, 1'b1, 1'b0);
        add(32'h00000000, 2'b00, 32'h00000000, 1'b0, 1'b0);
        add(32'h80000000, 2'b01, 32'h00000000, 1'b0, 1'b0);
        add(32'h3F000000, 2'b00, 32'h00000000, 1'b0, 1'b1);
        add(32'h3F000000, 2'b10, 32'h00000001, 1'b0, 1'b1);
        add(32'h3F400000, 2'b00, 32'h00000001, 1'b0, 1'b1);
        add(32'h3E800000, 2'b10, 32'h00000001, 1'b0, 1'b1);
        add(32'h3E800000, 2'b00, 32'h00000000, 1'b0, 1'b1);
        add(32'h3F7FFFFF, 2'b00, 32'h00000001, 1'b0, 1'b1);
        add(32'h3F7FFFFF, 2'b11, 32'h00000000, 1'b0, 1'b1);
        add(32'h4EFFFFFF, 2'b10, 32'h7FFFFF80, 1'b0, 1'b0);
        add(32'hC0200000, 2'b01, 32'hFFFFFFFD, 1'b0, 1'b1);
        add(32'hC0200000, 2'b00, 32'hFFFFFFFE, 1'b0, 1'b1);
        add(32'hC0200000, 2'b10, 32'hFFFFFFFE, 1'b0, 1'b1);
        add(32'h3FA00000, 2'b10, 32'h00000002, 1'b0, 1'b1);
        add(32'h40600000, 2'b00, 32'h00000004, 1'b0, 1'b1);
        add(32'h4B000001, 2'b00, 32'h00800001, 1'b0, 1'b0);
        add(32'h4B800001, 2'b11, 32'h01000002, 1'b0, 1'b0);

        // Reset state.
        #2;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_d", d, 32'd0);
`ifdef F2I_FLAGS_EN
        chk("reset_invalid", {31'b0, invalid}, 32'd0);
        chk("reset_inexact", {31'b0, inexact}, 32'd0);
`endif
        @(posedge clk); #1;
        clrn = 1'b1;

        // Back-to-back table vectors.
        foreach (vecs[i]) tick(1'b1, 1'b1, vecs[i]);
        idle(5);

        // Five valid inputs with a two-cycle stall in the middle.
        tick(1'b1, 1'b1, mk(32'h3F800000, 32'd1));
        tick(1'b1, 1'b1, mk(32'h40000000, 32'd2));
        tick(1'b1, 1'b1, mk(32'h40400000, 32'd3));
        tick(1'b0, 1'b1, mk(32'h41200000, 32'd10));
        tick(1'b0, 1'b1, mk(32'h41200000, 32'd10));
        tick(1'b1, 1'b1, mk(32'h40800000, 32'd4));
        tick(1'b1, 1'b1, mk(32'h40A00000, 32'd5));
        idle(2);
        tick(1'b0, 1'b0, mk(32'h0, 32'd0));
        tick(1'b0, 1'b0, mk(32'h0, 32'd0));
        idle(4);
        chk("stall_drained", 32'(sb.size()), 32'd0);

        // Reset with three operations in flight.
        tick(1'b1, 1'b1, mk(32'h41000000, 32'd8));
        tick(1'b1, 1'b1, mk(32'h41100000, 32'd9));
        tick(1'b1, 1'b1, mk(32'h41200000, 32'd10));
        clrn = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_d", d, 32'd0);
`ifdef F2I_FLAGS_EN
        chk("rst_invalid", {31'b0, invalid}, 32'd0);
        chk("rst_inexact", {31'b0, inexact}, 32'd0);
`endif
        sb.delete();
        held_valid = 1'b0;
        junk = mk(32'h41300000, 32'd11);
        tick(1'b1, 1'b1, junk);
        tick(1'b1, 1'b1, junk);
        clrn = 1'b1;
        idle(5);
        tick(1'b1, 1'b1, mk(32'h41400000, 32'd12));
        idle(4);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_float_to_int.md
PIPELINED_FLOAT_TO_INT -- requirements
Module: pipelined_float_to_int

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 e  input  1  pipeline advance enable; 0 freezes every stage.
REQ-005 in_valid  input  1  a/rm carry an operation this cycle.
REQ-006 a  input  32  IEEE-754 single-precision operand.
REQ-007 rm  input  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
REQ-008 out_valid  output  1  d (and flags) hold a result.
REQ-009 d  output  32  two's-complement signed 32-bit integer result.
REQ-010 invalid  output  1  NaN, infinity or out-of-range operand (present only under F2I_FLAGS_EN).
REQ-011 inexact  output  1  result differs from operand value (present only under F2I_FLAGS_EN).

Function
REQ-012 The pipeline SHALL have three register stages: S1 unpack/classify, S2 align shift, S3 round/negate/saturate, registered at the outputs.
REQ-013 With e=1 every cycle, a result SHALL appear on d/out_valid exactly 3 clk edges after the operation is presented.
REQ-014 in_valid SHALL propagate as a valid bit alongside the data; out_valid is the S3 copy.
REQ-015 When e=0 all stage registers, including valid bits, SHALL hold their values; there is no backpressure beyond e.
REQ-016 When in_valid=0 the data registers SHALL still load, but out_valid SHALL be 0 for that slot.
REQ-017 S1: sign=a[31], exp=a[30:23], mant={hidden,a[22:0]} with hidden=|exp; classify NaN (exp=FF, frac!=0), inf (exp=FF, frac=0), zero/denormal (exp=0).
REQ-018 S2: unbiased exponent E=exp-127; mant SHALL be shifted into a 32-bit integer field plus guard, round and sticky bits; E<-1 yields integer 0, with sticky = OR of all mant bits.
REQ-019 S2: E>=31 SHALL set a pre-overflow flag without performing the shift.
REQ-020 S3 increment rule: rm=00: guard & (round|sticky|lsb); rm=01: sign & (guard|round|sticky); rm=10: ~sign & (guard|round|sticky); rm=11: never.
REQ-021 S3 SHALL round the magnitude in 33 bits, then negate when sign=1.
REQ-022 Saturation: NaN -> 0x7FFFFFFF; +inf or positive rounded magnitude > 2^31-1 -> 0x7FFFFFFF; -inf or negative rounded magnitude > 2^31 -> 0x80000000; all of these set invalid=1.
REQ-023 -2^31 exactly (0xCF000000) SHALL give 0x80000000 with invalid=0.
REQ-024 ±0 SHALL give 0x00000000 with no flags.
REQ-025 Denormals SHALL be rounded per REQ-020, e.g. negative denormal with rm=01 gives 0xFFFFFFFF.
REQ-026 inexact SHALL be 1 iff (guard|round|sticky)=1 and invalid=0.

Reset
REQ-027 clrn=0 SHALL immediately clear all stage registers: out_valid=0, d=0, invalid=0, inexact=0.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; none appear after release.

Configuration
REQ-029 Macro F2I_FLAGS_EN defined: the invalid and inexact ports, and the flag bits carried through S1-S3, SHALL exist and behave per REQ-022..026.
REQ-030 Macro F2I_FLAGS_EN undefined: those ports and flag registers SHALL be absent; d and out_valid behaviour is unchanged.

Structure
REQ-031 The shared float package SHALL hold the rounding-mode constants (RM_NEAREST, RM_DOWN, RM_UP, RM_ZERO), float field widths, exponent bias 127, and the saturation constants INT_MAX=0x7FFFFFFF and INT_MIN=0x80000000.
REQ-032 S3 combinational logic SHALL be a sub-module, float_to_int_round_stage; stage registers stay in the top module.

Verification
REQ-033 a=0x3FC00000 (1.5), rm=00 -> d=0x00000002 after 3 cycles, inexact=1, invalid=0.
REQ-034 a=0x40200000 (2.5): rm=00 -> 0x00000002; rm=10 -> 0x00000003; rm=11 -> 0x00000002; inexact=1 in all three cases.
REQ-035 a=0xBF800000 (-1.0), any rm -> 0xFFFFFFFF with no flags; a=0x80000001, rm=01 -> 0xFFFFFFFF, inexact=1; same a with rm=00 -> 0x00000000, inexact=1.
REQ-036 a=0xCF000000 -> 0x80000000, invalid=0; a=0x4F000000 -> 0x7FFFFFFF, invalid=1; a=0x7FC00000 -> 0x7FFFFFFF, invalid=1; a=0xFF800000 -> 0x80000000, invalid=1.
REQ-037 Five back-to-back valid inputs with e=0 for 2 cycles mid-stream -> five results in order, each held during the stall, with no duplicated or dropped out_valid.
REQ-038 clrn pulsed low with 3 operations in flight -> all outputs 0 immediately, and no out_valid until new inputs have traversed the 3 stages.
